qsys_cpu_div_cell: RTL and testbench



---
 rtl/qsys_cpu_div_pkg.sv | 14 +
 rtl/qsys_cpu_div_step.sv | 24 ++
 rtl/qsys_cpu_div_cell.sv | 136 +++++++++++++
 tb/tb_qsys_cpu_div_cell.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/qsys_cpu_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package qsys_cpu_div_pkg;

  // Default operand/result width and the matching iteration-counter width.
  localparam int unsigned DivWidth    = 32;
  localparam int unsigned DivCntWidth = $clog2(DivWidth);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } div_state_e;

endpackage

// File: rtl/qsys_cpu_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module qsys_cpu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] prem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction is one bit wider so its MSB acts as the borrow/sign.
  always_comb begin
    shifted = {prem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[WIDTH];
    prem_o  = q_bit_o ? trial[WIDTH-1:0] : {prem_i[WIDTH-2:0], dvd_msb_i};
  end

endmodule

// File: rtl/qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu. Operands are converted to
// magnitudes on start, WIDTH restoring steps run one per cycle, and a final
// cycle applies sign correction and pulses div_done.
module qsys_cpu_div_cell
  import qsys_cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             div_kill,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  // Holds the dividend magnitude; quotient bits shift in at the LSB as the
  // dividend shifts out of the MSB, so after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_prem;
  logic             step_q;

  qsys_cpu_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem_i   (prem_q),
    .dvd_msb_i(dvd_q[WIDTH-1]),
    .dvs_i    (dvs_q),
    .prem_o   (step_prem),
    .q_bit_o  (step_q)
  );

  // Next-state logic: operand capture, iteration, sign fix and abort handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Kill wins over start so a flushed instruction never begins.
        if (div_start && !div_kill) begin
          dvd_d   = (div_signed && div_src1[WIDTH-1]) ? (~div_src1 + WIDTH'(1)) : div_src1;
          dvs_d   = (div_signed && div_src2[WIDTH-1]) ? (~div_src2 + WIDTH'(1)) : div_src2;
          q_neg_d = div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
          r_neg_d = div_signed & div_src1[WIDTH-1];
          prem_d  = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (div_kill) begin
          state_d = StIdle;
        end else begin
          prem_d = step_prem;
          dvd_d  = {dvd_q[WIDTH-2:0], step_q};
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!div_kill) begin
          quo_d  = q_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          rem_d  = r_neg_q ? (~prem_q + WIDTH'(1)) : prem_q;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Busy covers the iteration and sign-fix cycles.
  always_comb begin
    div_busy      = (state_q != StIdle);
    div_done      = done_q;
    div_quotient  = quo_q;
    div_remainder = rem_q;
  end

endmodule

// File: tb/tb_qsys_cpu_div_cell.sv
// Self-checking bench for qsys_cpu_div_cell: directed cases, handshake and
// abort scenarios, then back-to-back random operations against a model.
module tb_qsys_cpu_div_cell;

  localparam int unsigned W = 32;
  localparam int Latency = 34;

  logic         clk;
  logic         reset;
  logic         div_start;
  logic         div_signed;
  logic         div_kill;
  logic [W-1:0] div_src1;
  logic [W-1:0] div_src2;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  qsys_cpu_div_cell #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_kill     (div_kill),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: C truncating division on 64-bit integers plus the defined
  // divide-by-zero results.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = (s && a[W-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(1, 15));
      4:       return -W'($urandom_range(1, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Issues one operation at the current negedge and waits for done. A second
  // start with other operands is poked at cycle poke_cyc (if >= 0); it must be
  // ignored. Returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input string tag, input int poke_cyc);
    int cyc = 0;
    int busy_bad = 0;
    bit seen = 0;
    div_src1   = a;
    div_src2   = b;
    div_signed = s;
    div_start  = 1'b1;
    div_kill   = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      div_start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        div_src1 = 32'd9;
        div_src2 = 32'd2;
      end
      if (div_done) seen = 1;
      else if (div_busy !== 1'b1) busy_bad++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(Latency));
    check_eq({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check_eq({tag, "_busy_done"}, {63'd0, div_busy}, 64'd0);
    check_eq({tag, "_quo"}, {32'd0, div_quotient}, {32'd0, eq});
    check_eq({tag, "_rem"}, {32'd0, div_remainder}, {32'd0, er});
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         rs;
    int           cyc;
    int           done_seen;

    reset      = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_kill   = 1'b0;
    div_src1   = '0;
    div_src2   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", {63'd0, div_busy}, 64'd0);
    check_eq("rst_done", {63'd0, div_done}, 64'd0);
    check_eq("rst_quo", {32'd0, div_quotient}, 64'd0);
    check_eq("rst_rem", {32'd0, div_remainder}, 64'd0);

    // Directed cases with hand-derived results.
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7", -1);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "sm100_7", -1);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, "s100_m7", -1);
    run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, "u5_0", -1);
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFB, "sm5_0", -1);
    run_op(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, "s5_0", -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "s_ovf", -1);
    run_op(32'h8000_0000, 32'd2, 1'b0, 32'h4000_0000, 32'd0, "u_big", -1);
    run_op(32'hFFFF_FFF9, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'd0, "s_zero_rem", -1);

    // Start while busy is ignored; then back-to-back start in the done cycle.
    run_op(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, "ign", 10);
    run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, "b2b", -1);

    // Kill has priority over start in idle.
    div_src1  = 32'd50;
    div_src2  = 32'd5;
    div_start = 1'b1;
    div_kill  = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    div_kill  = 1'b0;
    check_eq("idle_kill_busy", {63'd0, div_busy}, 64'd0);

    // Abort mid-calculation: no done, outputs hold the previous result.
    div_start  = 1'b1;
    div_signed = 1'b0;
    cyc        = 0;
    done_seen  = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      div_start = 1'b0;
      div_kill  = (cyc == 12);
      if (cyc == 12) check_eq("kill_busy_before", {63'd0, div_busy}, 64'd1);
      if (cyc == 13) check_eq("kill_busy_after", {63'd0, div_busy}, 64'd0);
      if (div_done) done_seen++;
    end
    check_eq("kill_no_done", 64'(done_seen), 64'd0);
    check_eq("kill_quo_hold", {32'd0, div_quotient}, {32'd0, last_q});
    check_eq("kill_rem_hold", {32'd0, div_remainder}, {32'd0, last_r});

    // Reset in the middle of an operation clears everything.
    div_src1  = 32'd77;
    div_src2  = 32'd3;
    div_start = 1'b1;
    cyc       = 0;
    while (cyc < 21) begin
      @(negedge clk);
      cyc++;
      div_start = 1'b0;
      reset     = (cyc == 20);
    end
    check_eq("mrst_busy", {63'd0, div_busy}, 64'd0);
    check_eq("mrst_done", {63'd0, div_done}, 64'd0);
    check_eq("mrst_quo", {32'd0, div_quotient}, 64'd0);
    check_eq("mrst_rem", {32'd0, div_remainder}, 64'd0);
    @(negedge clk);

    // Random back-to-back operations against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, mq, mr);
      run_op(ra, rb, rs, mq, mr, "rnd", -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
